// File: rtl/mult_add_seq.sv
// Sequential shift-and-add checker: rebuilds quotient*denom+remain and compares it
// with the expected numerator to verify a divider result.
module mult_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     denom,
    input  logic [WIDTH-1:0]     remain,
    input  logic [WIDTH-1:0]     numer,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 match,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   denom_q;
    logic [WIDTH-1:0]   remain_q;
    logic [WIDTH-1:0]   numer_q;
    logic [CW-1:0]      count;
    logic               steps_done;

    // BUSY spends one extra cycle after the last step to register the outputs.
    assign steps_done = (count == CW'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (steps_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            denom_q     <= '0;
            remain_q    <= '0;
            numer_q     <= '0;
            result      <= '0;
            match       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            acc      <= {{WIDTH{1'b0}}, remain};
            mcand    <= {{WIDTH{1'b0}}, denom};
            mplier   <= quotient;
            count    <= '0;
            denom_q  <= denom;
            remain_q <= remain;
            numer_q  <= numer;
        end else if (state == BUSY) begin
            if (!steps_done) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
            end else begin
                // A zero denominator can never be a consistent division result.
                result      <= acc;
                match       <= (acc == {{WIDTH{1'b0}}, numer_q}) &&
                               (denom_q != '0) && (remain_q < denom_q);
                div_by_zero <= (denom_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_mult_add_seq.sv
// Directed bench for mult_add_seq: latency, arithmetic, backpressure, reset abort
// and back-to-back streaming, with hand-computed expectations.
module tb_mult_add_seq;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   denom;
    logic [WIDTH-1:0]   remain;
    logic [WIDTH-1:0]   numer;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               match;
    logic               div_by_zero;

    int checks;
    int errors;

    mult_add_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .quotient    (quotient),
        .denom       (denom),
        .remain      (remain),
        .numer       (numer),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .match       (match),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] d,
                                  input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] n);
        quotient = q;
        denom    = d;
        remain   = r;
        numer    = n;
        in_valid = 1'b1;
    endtask

    // Accepts one op, checks out_valid is absent at edge 16 and present at edge 17.
    task automatic run_op(input string tag,
                          input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] n,
                          input logic [2*WIDTH-1:0] exp_result, input logic exp_match,
                          input logic exp_dbz);
        check_output({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        apply_stimulus(q, d, r, n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_output({tag, "_valid_edge16"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_output({tag, "_valid_edge17"}, 64'(out_valid), 64'd1);
        check_output({tag, "_result"}, 64'(result), 64'(exp_result));
        check_output({tag, "_match"}, 64'(match), 64'(exp_match));
        check_output({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check_output({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    logic [WIDTH-1:0]   bq[4];
    logic [WIDTH-1:0]   bd[4];
    logic [WIDTH-1:0]   br[4];
    logic [WIDTH-1:0]   bn[4];
    logic [2*WIDTH-1:0] bres[4];
    logic               bmatch[4];
    logic               saw_valid;

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        denom     = '0;
        remain    = '0;
        numer     = '0;
        rst_n     = 1'b0;

        #3;
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_result", 64'(result), 64'd0);
        check_output("rst_match", 64'(match), 64'd0);
        check_output("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic");
        run_op("basic", 16'd4, 16'd5, 16'd0, 16'd20, 32'd20, 1'b1, 1'b0);
        handshake("basic");

        $display("[TB] max");
        run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, 1'b0, 1'b0);
        handshake("max");

        $display("[TB] numer mismatch");
        run_op("nmis", 16'd4, 16'd5, 16'd0, 16'd21, 32'd20, 1'b0, 1'b0);
        handshake("nmis");

        $display("[TB] divide by zero");
        run_op("dbz", 16'd7, 16'd0, 16'd3, 16'd3, 32'd3, 1'b0, 1'b1);
        handshake("dbz");

        $display("[TB] backpressure");
        run_op("bp", 16'd12, 16'd11, 16'd10, 16'd142, 32'd142, 1'b1, 1'b0);
        apply_stimulus(16'd9, 16'd9, 16'd9, 16'd9);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_output("bp_hold_valid", 64'(out_valid), 64'd1);
            check_output("bp_hold_ready", 64'(in_ready), 64'd0);
            check_output("bp_hold_result", 64'(result), 64'd142);
            check_output("bp_hold_match", 64'(match), 64'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check_output("bp_ignored_op_valid", 64'(saw_valid), 64'd0);
        check_output("bp_ignored_op_ready", 64'(in_ready), 64'd1);

        $display("[TB] reset mid-op");
        apply_stimulus(16'd50, 16'd50, 16'd1, 16'd2501);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("rmid_ready", 64'(in_ready), 64'd1);
        check_output("rmid_valid", 64'(out_valid), 64'd0);
        check_output("rmid_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check_output("rmid_no_valid", 64'(saw_valid), 64'd0);
        run_op("rnext", 16'd3, 16'd6, 16'd2, 16'd20, 32'd20, 1'b1, 1'b0);
        handshake("rnext");

        $display("[TB] back-to-back");
        bq[0] = 16'd10;  bd[0] = 16'd3;   br[0] = 16'd1;   bn[0] = 16'd31;
        bres[0] = 32'd31;    bmatch[0] = 1'b1;
        bq[1] = 16'd0;   bd[1] = 16'd9;   br[1] = 16'd5;   bn[1] = 16'd5;
        bres[1] = 32'd5;     bmatch[1] = 1'b1;
        bq[2] = 16'd100; bd[2] = 16'd7;   br[2] = 16'd7;   bn[2] = 16'd707;
        bres[2] = 32'd707;   bmatch[2] = 1'b0;
        bq[3] = 16'd200; bd[3] = 16'd300; br[3] = 16'd299; bn[3] = 16'd60299;
        bres[3] = 32'd60299; bmatch[3] = 1'b1;
        out_ready = 1'b1;
        apply_stimulus(bq[0], bd[0], br[0], bn[0]);
        @(posedge clk); #1;
        check_output("b2b_accept0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply_stimulus(bq[i+1], bd[i+1], br[i+1], bn[i+1]);
            else in_valid = 1'b0;
            repeat (16) @(posedge clk);
            #1;
            check_output("b2b_valid_edge16", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            check_output("b2b_valid_edge17", 64'(out_valid), 64'd1);
            check_output("b2b_result", 64'(result), 64'(bres[i]));
            check_output("b2b_match", 64'(match), 64'(bmatch[i]));
            check_output("b2b_dbz", 64'(div_by_zero), 64'd0);
            @(posedge clk); #1;
            check_output("b2b_idle_ready", 64'(in_ready), 64'd1);
            if (i < 3) begin
                @(posedge clk); #1;
                check_output("b2b_accept_next", 64'(in_ready), 64'd0);
            end
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("b2b_final_idle", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
